// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and instruction-RAM signal bundle for imem_port_arbiter.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface imem_port_arbiter_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH = 32
);
    logic                   fetch_req;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic                   fetch_gnt;
    logic                   fetch_rvalid;
    logic [INSTR_WIDTH-1:0] fetch_rdata;

    logic                   load_req;
    logic [ADDR_WIDTH-1:0]  load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   load_last;
    logic                   load_gnt;

    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_di;
    logic [INSTR_WIDTH-1:0] mem_dout;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        input  load_req, load_addr, load_data, load_last,
        output load_gnt,
        output mem_en, mem_we, mem_addr, mem_di,
        input  mem_dout
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        output load_req, load_addr, load_data, load_last,
        input  load_gnt,
        input  mem_en, mem_we, mem_addr, mem_di,
        output mem_dout
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port instruction RAM between CPU fetch and a burst loader.
// Define IMEM_ARB_STARVE_GUARD_EN to force a loader grant after STARVE_LIMIT denials.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int INSTR_WIDTH  = 32,
    parameter int STARVE_LIMIT = 8
) (
    input logic            clk,
    input logic            rst_n,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   rvalid_q, rvalid_d;
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;
    logic                   fetch_gnt;
    logic                   load_gnt;
    logic                   starve_force;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    assign starve_force = rst_n && (state_q == IDLE) &&
                          bus.load_req && (starve_q == LIMIT);

    // Saturating count of IDLE cycles where the loader asked and lost
    always_comb begin
        starve_d = starve_q;
        if (load_gnt) begin
            starve_d = '0;
        end else if ((state_q == IDLE) && bus.load_req &&
                     (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starve_force = 1'b0;
`endif

    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        state_d   = state_q;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (starve_force) begin
                        load_gnt = 1'b1;
                    end else if (bus.fetch_req) begin
                        fetch_gnt = 1'b1;
                    end else if (bus.load_req) begin
                        load_gnt = 1'b1;
                    end
                end
                BURST: begin
                    load_gnt = bus.load_req;
                end
                default: ;
            endcase
            if (load_gnt) begin
                state_d = bus.load_last ? IDLE : BURST;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        rvalid_d = fetch_gnt;
        hold_d   = hold_q;
        if (rvalid_q) begin
            hold_d = bus.mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.load_gnt     = load_gnt;
    assign bus.fetch_rvalid = rvalid_q;
    // RAM output is only live in the cycle after a read; hold it otherwise
    assign bus.fetch_rdata  = rvalid_q ? bus.mem_dout : hold_q;

    assign bus.mem_en   = fetch_gnt | load_gnt;
    assign bus.mem_we   = load_gnt;
    assign bus.mem_addr = fetch_gnt ? bus.fetch_addr :
                          load_gnt  ? bus.load_addr  : '0;
    assign bus.mem_di   = load_gnt ? bus.load_data : '0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fetch_gnt && load_gnt));
        end
    end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a no-change RAM model.
// Expectations for the starvation case follow IMEM_ARB_STARVE_GUARD_EN.
module tb_imem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    imem_port_arbiter_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(DW)) bus ();

    imem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (DW),
        .STARVE_LIMIT(8)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] dout_q = '0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_di;
            else            dout_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_dout = dout_q;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input logic fr, input logic [AW-1:0] fa,
                         input logic lr, input logic [AW-1:0] la,
                         input logic [DW-1:0] ld, input logic ll);
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.load_req   = lr;
        bus.load_addr  = la;
        bus.load_data  = ld;
        bus.load_last  = ll;
    endtask

    task automatic chk_gnt(input string tag, input logic fg, input logic lg);
        settle();
        chk({tag, ".fgnt"}, 32'(bus.fetch_gnt), 32'(fg));
        chk({tag, ".lgnt"}, 32'(bus.load_gnt), 32'(lg));
    endtask

    task automatic chk_rd(input string tag, input logic v, input logic [DW-1:0] d);
        settle();
        chk({tag, ".rvalid"}, 32'(bus.fetch_rvalid), 32'(v));
        chk({tag, ".rdata"}, bus.fetch_rdata, d);
    endtask

    logic exp_l;

    initial begin
        drive(1'b1, 10'd0, 1'b0, 10'd0, '0, 1'b0);
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_gnt("rst", 1'b0, 1'b0);
            chk_rd("rst", 1'b0, 32'h0);
            chk("rst.mem_en", 32'(bus.mem_en), 32'h0);
            tick();
        end
        rst_n = 1'b1;

        // Burst of three words with fetch pending from the second word
        drive(1'b0, 10'd0, 1'b1, 10'd0, 32'h11111111, 1'b0);
        chk_gnt("b0", 1'b0, 1'b1);
        chk("b0.we", 32'(bus.mem_we), 32'h1);
        chk("b0.addr", 32'(bus.mem_addr), 32'h0);
        chk("b0.di", bus.mem_di, 32'h11111111);
        tick();
        drive(1'b1, 10'd0, 1'b1, 10'd1, 32'h22222222, 1'b0);
        chk_gnt("b1", 1'b0, 1'b1);
        tick();
        drive(1'b1, 10'd0, 1'b1, 10'd2, 32'h33333333, 1'b1);
        chk_gnt("b2", 1'b0, 1'b1);
        tick();
        drive(1'b1, 10'd0, 1'b0, 10'd0, '0, 1'b0);
        chk_gnt("f0", 1'b1, 1'b0);
        chk("f0.en", 32'(bus.mem_en), 32'h1);
        chk("f0.we", 32'(bus.mem_we), 32'h0);
        chk("f0.addr", 32'(bus.mem_addr), 32'h0);
        tick();
        drive(1'b1, 10'd1, 1'b0, 10'd0, '0, 1'b0);
        chk_rd("f1", 1'b1, 32'h11111111);
        chk_gnt("f1", 1'b1, 1'b0);
        tick();
        drive(1'b1, 10'd2, 1'b0, 10'd0, '0, 1'b0);
        chk_rd("f2", 1'b1, 32'h22222222);
        tick();
        drive(1'b0, 10'd0, 1'b0, 10'd0, '0, 1'b0);
        chk_rd("f3", 1'b1, 32'h33333333);
        chk_gnt("f3", 1'b0, 1'b0);
        tick();
        chk_rd("hold", 1'b0, 32'h33333333);

        // IDLE contention: fetch first, loader when fetch drops
        drive(1'b1, 10'd2, 1'b1, 10'd7, 32'hA5A5A5A5, 1'b1);
        chk_gnt("ct0", 1'b1, 1'b0);
        tick();
        drive(1'b0, 10'd0, 1'b1, 10'd7, 32'hA5A5A5A5, 1'b1);
        chk_gnt("ct1", 1'b0, 1'b1);
        chk_rd("ct1", 1'b1, 32'h33333333);
        tick();

        // Read-after-write
        drive(1'b0, 10'd0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b1);
        chk_gnt("raw0", 1'b0, 1'b1);
        tick();
        drive(1'b1, 10'd5, 1'b0, 10'd0, '0, 1'b0);
        chk_gnt("raw1", 1'b1, 1'b0);
        tick();
        drive(1'b0, 10'd0, 1'b0, 10'd0, '0, 1'b0);
        chk_rd("raw2", 1'b1, 32'hDEADBEEF);
        tick();

        // Burst with an idle gap, then reset mid-burst
        drive(1'b0, 10'd0, 1'b1, 10'd8, 32'h80000000, 1'b0);
        chk_gnt("mb0", 1'b0, 1'b1);
        tick();
        drive(1'b1, 10'd3, 1'b0, 10'd0, '0, 1'b0);
        chk_gnt("mbgap", 1'b0, 1'b0);
        chk("mbgap.en", 32'(bus.mem_en), 32'h0);
        tick();
        drive(1'b1, 10'd3, 1'b1, 10'd9, 32'h90000000, 1'b0);
        chk_gnt("mb1", 1'b0, 1'b1);
        tick();
        drive(1'b1, 10'd3, 1'b1, 10'd10, 32'hA0000000, 1'b0);
        rst_n = 1'b0;
        chk_gnt("mbrst", 1'b0, 1'b0);
        chk("mbrst.en", 32'(bus.mem_en), 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 10'd8, 1'b0, 10'd0, '0, 1'b0);
        chk_gnt("mbpost", 1'b1, 1'b0);
        chk_rd("mbpost", 1'b0, 32'h0);
        tick();
        drive(1'b0, 10'd0, 1'b0, 10'd0, '0, 1'b0);
        chk_rd("mbpost2", 1'b1, 32'h80000000);
        tick();

        // Starvation: loader pending under continuous fetch
        drive(1'b1, 10'd1, 1'b1, 10'd20, 32'h5A5A5A5A, 1'b1);
        for (int i = 1; i <= 9; i++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
            exp_l = (i == 9);
`else
            exp_l = 1'b0;
`endif
            chk_gnt($sformatf("stv%0d", i), ~exp_l, exp_l);
            tick();
        end
        drive(1'b0, 10'd0, 1'b0, 10'd0, '0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbiter and sequencer for the single-port, no-change-mode instruction block RAM (1024 × INSTR_WIDTH). It shares the RAM between the CPU fetch port (read-only) and the program loader (write-only, burst capable), and drives the RAM's en/we/addr/di. It returns fetch data with a fixed one-cycle latency. It sits between the fetch stage and the loader on one side and the instruction RAM on the other.

## Interface
- ADDR_WIDTH, 10, word address width (RAM depth 2^ADDR_WIDTH)
- INSTR_WIDTH, 32, instruction/data word width
- STARVE_LIMIT, 8, consecutive loader denials before a forced loader grant (used only with IMEM_ARB_STARVE_GUARD_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- fetch_req  in  1  fetch read request
- fetch_addr  in  ADDR_WIDTH  fetch word address
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_rvalid  out  1  fetch_rdata valid (registered)
- fetch_rdata  out  INSTR_WIDTH  read data
- load_req  in  1  loader write request
- load_addr  in  ADDR_WIDTH  write word address
- load_data  in  INSTR_WIDTH  write data
- load_last  in  1  final word of the burst, qualified by load_req
- load_gnt  out  1  write accepted this cycle (combinational)
- mem_en, mem_we  out  1  RAM enable and write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_di  out  INSTR_WIDTH  RAM write data
- mem_dout  in  INSTR_WIDTH  RAM read data, valid one cycle after a read

## Operation
- FSM states: IDLE and BURST.
- **IDLE:**
  - If fetch_req is asserted, fetch wins (fixed priority).
  - Otherwise, if load_req is asserted, the loader wins.
  - A load grant without load_last moves the FSM to BURST.
- **BURST:**
  - Only the loader is granted; fetch_gnt = 0.
  - The FSM stays in BURST until a granted load has load_last = 1, then returns to IDLE.
  - load_req low in BURST is an idle cycle: no RAM access, state held.
- **RAM drive on a fetch grant:** mem_en = 1, mem_we = 0, mem_addr = fetch_addr.
- **RAM drive on a load grant:** mem_en = 1, mem_we = 1, mem_addr = load_addr, mem_di = load_data.
- **RAM drive with no grant:** mem_en = 0, mem_we = 0; mem_addr and mem_di are don't-care.
- At most one grant per cycle. fetch_gnt and load_gnt are never both 1.
- fetch_rdata:
  - In the cycle when fetch_rvalid = 1, fetch_rdata equals mem_dout.
  - A hold register captures that value and drives fetch_rdata at all other times.

## Timing
- **Reset values:**
  - fetch_rvalid = 0, hold register = 0, FSM = IDLE, starvation counter = 0.
  - Combinational outputs are 0 while rst_n = 0.
- Fetch latency is 1: a grant in cycle N gives fetch_rvalid = 1 in cycle N+1. Back-to-back fetches give one word per cycle.
- Write latency: the RAM is written at the edge that ends the grant cycle.
- **Read-after-write to the same address:** a write granted in cycle N followed by a read granted in cycle N+1 returns the new data.
- **Simultaneous fetch and load requests:**
  - In IDLE, fetch is granted.
  - In BURST, load is granted.
- **Reset mid-burst:**
  - The FSM returns to IDLE.
  - A read granted in the reset cycle does not produce fetch_rvalid.
- Requesters hold addr and data stable until granted.

## Configuration
- **IMEM_ARB_STARVE_GUARD_EN defined:**
  - In IDLE, a saturating counter increments on each cycle where load_req = 1 and load_gnt = 0.
  - When the counter reaches STARVE_LIMIT, the next IDLE cycle with load_req = 1 grants the loader even if fetch_req = 1.
  - The counter clears on any load grant.
- **IMEM_ARB_STARVE_GUARD_EN undefined:** strict fetch priority in IDLE, no counter logic.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles with fetch_req = 1 → all grants 0, fetch_rvalid = 0, fetch_rdata = 0.
- **Burst load then fetch:**
  - Load burst of words 0x11111111, 0x22222222 and 0x33333333 (last) to addresses 0–2, with fetch_req held high from cycle 1 → fetch_gnt = 0 until load_last is granted.
  - Fetch then reads addresses 0, 1, 2 back-to-back → fetch_rvalid in cycles N+1..N+3 with the matching data.
- **Contention in IDLE:** fetch_req = 1 and load_req = 1 with load_last = 1 → fetch granted. Load granted the first cycle fetch_req = 0.
- **Read-after-write:** write 0xDEADBEEF to address 5, then fetch address 5 the next cycle → fetch_rdata = 0xDEADBEEF.
- **Reset mid-burst:** after 2 of 4 burst words, pulse rst_n low for 1 cycle → FSM returns to IDLE, and the next fetch_req is granted immediately.
- **Starvation guard (IMEM_ARB_STARVE_GUARD_EN):** continuous fetch_req with load_req = 1 and STARVE_LIMIT = 8 → load_gnt = 1 on the 9th cycle. Without the macro, load_gnt stays 0.
